// File: rtl/rice_bus_if.sv
// CSR bus shared by the CSR initiator and the CSR responders.
// The request channel carries address, direction and write data. Writes are
// non-posted, so every accepted request gets exactly one response beat.
interface rice_bus_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int XLEN          = 32
);
    logic                     request_valid;
    logic                     request_ready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic                     write;
    logic [XLEN-1:0]          write_data;
    logic                     response_valid;
    logic                     response_ready;
    logic [XLEN-1:0]          read_data;
    logic                     error;

    modport master (
        output request_valid, address, write, write_data, response_ready,
        input  request_ready, response_valid, read_data, error
    );

    modport slave (
        input  request_valid, address, write, write_data, response_ready,
        output request_ready, response_valid, read_data, error
    );
endinterface

// File: rtl/rice_core_csr_access.sv
// Zicsr execute-stage CSR bus initiator.
// Turns one CSRRW/CSRRS/CSRRC (or immediate form) into an optional read and
// an optional write on the CSR bus, does the read-modify-write locally and
// reports the old CSR value or an illegal-instruction error.
// Optional feature: define RICE_CORE_CSR_READ_ONLY_CHECK_EN to reject writes
// to the read-only CSR space (address[11:10] == 2'b11) without bus traffic.
module rice_core_csr_access #(
    parameter int XLEN          = 32,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [1:0]               i_op,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [XLEN-1:0]          i_operand,
    input  logic                     i_rs1_zero,
    input  logic                     i_rd_zero,
    input  logic                     i_flush,
    output logic                     o_done,
    output logic [XLEN-1:0]          o_rd_value,
    output logic                     o_error,
    output logic                     o_busy,
    rice_bus_if.master               csr_if
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Instruction fields captured at acceptance (datapath, no reset needed)
    logic [1:0]               op;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [XLEN-1:0]          operand;
    logic [XLEN-1:0]          old_value;
    logic [XLEN-1:0]          write_data;

    // Control flags
    logic need_write;
    logic read_issued;
    logic error_flag;
    logic kill;

    // Request-time decode
    logic need_read_in;
    logic need_write_in;
    logic ro_violation;
    logic illegal_in;
    logic accept;
    logic kill_now;
    logic response_error;

    assign need_read_in  = !((i_op == OP_RW) && i_rd_zero);
    assign need_write_in = (i_op == OP_RW) || !i_rs1_zero;

`ifdef RICE_CORE_CSR_READ_ONLY_CHECK_EN
    assign ro_violation = need_write_in &&
                          (i_address[ADDRESS_WIDTH-1 -: 2] == 2'b11);
`else
    assign ro_violation = 1'b0;
`endif

    assign illegal_in     = (i_op == 2'b00) || ro_violation;
    assign accept         = (state == IDLE) && i_valid && !i_flush;
    // A flush arriving this very cycle counts as well as a remembered one
    assign kill_now       = kill || i_flush;
    assign response_error = csr_if.response_valid && csr_if.error;

    // Next-state and Moore outputs of the transaction sequencer
    always_comb begin
        state_next           = state;
        csr_if.request_valid = 1'b0;
        csr_if.write         = 1'b0;
        o_done               = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && !i_flush) begin
                    if (illegal_in) begin
                        state_next = DONE;
                    end else if (need_read_in) begin
                        state_next = RD_REQ;
                    end else if (need_write_in) begin
                        state_next = WR_REQ;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            RD_REQ: begin
                csr_if.request_valid = 1'b1;
                if (csr_if.request_ready) begin
                    state_next = RD_RSP;
                end
            end
            RD_RSP: begin
                if (csr_if.response_valid) begin
                    if (csr_if.error || kill_now || !need_write) begin
                        state_next = DONE;
                    end else begin
                        state_next = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                // An already asserted write is never withdrawn, even on flush
                csr_if.request_valid = 1'b1;
                csr_if.write         = 1'b1;
                if (csr_if.request_ready) begin
                    state_next = WR_RSP;
                end
            end
            WR_RSP: begin
                if (csr_if.response_valid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                o_done     = !kill_now;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and control flags
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            need_write  <= 1'b0;
            read_issued <= 1'b0;
            error_flag  <= 1'b0;
            kill        <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                need_write  <= need_write_in;
                read_issued <= need_read_in && !illegal_in;
                error_flag  <= illegal_in;
                kill        <= 1'b0;
            end else begin
                if (i_flush && (state != IDLE)) begin
                    kill <= 1'b1;
                end
                if (response_error && ((state == RD_RSP) || (state == WR_RSP))) begin
                    error_flag <= 1'b1;
                end
            end
        end
    end

    // Instruction capture and old-value register
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op      <= i_op;
            address <= i_address;
            operand <= i_operand;
        end
        if ((state == RD_RSP) && csr_if.response_valid) begin
            old_value <= csr_if.read_data;
        end
    end

    // Read-modify-write data; stable for the whole WR_REQ phase
    always_comb begin
        case (op)
            OP_RS:   write_data = old_value | operand;
            OP_RC:   write_data = old_value & ~operand;
            default: write_data = operand;
        endcase
    end

    assign csr_if.address        = address;
    assign csr_if.write_data     = write_data;
    assign csr_if.response_ready = 1'b1;

    assign o_ready    = (state == IDLE);
    assign o_busy     = (state != IDLE);
    assign o_rd_value = read_issued ? old_value : '0;
    assign o_error    = o_done && error_flag;

    // Responses are only legal while a response is being waited for
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
        csr_if.response_valid |-> ((state == RD_RSP) || (state == WR_RSP)));

endmodule

// File: tb/tb_rice_core_csr_access.sv
// Bench for rice_core_csr_access: directed Zicsr cases plus randomized
// instructions against a CSR-file reference model and a stalling bus slave.
module tb_rice_core_csr_access;

    localparam int XLEN = 32;
    localparam int AW   = 12;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            valid = 1'b0;
    logic            ready;
    logic [1:0]      op = '0;
    logic [AW-1:0]   addr = '0;
    logic [XLEN-1:0] operand = '0;
    logic            rs1z = 1'b0;
    logic            rdz = 1'b0;
    logic            flush = 1'b0;
    logic            done;
    logic [XLEN-1:0] rdv;
    logic            err;
    logic            busy;

    always #5 clk = ~clk;

    rice_bus_if #(.ADDRESS_WIDTH(AW), .XLEN(XLEN)) bus ();

    rice_core_csr_access #(.XLEN(XLEN), .ADDRESS_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_op       (op),
        .i_address  (addr),
        .i_operand  (operand),
        .i_rs1_zero (rs1z),
        .i_rd_zero  (rdz),
        .i_flush    (flush),
        .o_done     (done),
        .o_rd_value (rdv),
        .o_error    (err),
        .o_busy     (busy),
        .csr_if     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // CSR map of the simulated responder
    function automatic bit mapped(input logic [AW-1:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h343, 12'hC00, 12'hF11};
    endfunction

    function automatic bit read_only(input logic [AW-1:0] a);
        return a[11:10] == 2'b11;
    endfunction

    logic [31:0] bus_mem [0:4095];
    logic [31:0] ref_mem [0:4095];

    int          cyc = 0;
    int          n_reads = 0;
    int          n_writes = 0;
    logic [31:0] last_wdata = '0;
    logic [31:0] last_rdata = '0;
    int          stall_target = 0;
    int          resp_delay = 0;
    bit          rand_mode = 0;

    always @(posedge clk) cyc++;

    // Bus slave: decides ready and responses on the falling edge
    initial begin : slave
        int          wait_cnt;
        int          resp_cnt;
        bit          pend;
        logic [31:0] pend_data;
        logic        pend_err;
        wait_cnt = 0;
        resp_cnt = 0;
        pend = 0;
        pend_data = '0;
        pend_err = 1'b0;
        bus.request_ready  = 1'b0;
        bus.response_valid = 1'b0;
        bus.read_data      = '0;
        bus.error          = 1'b0;
        forever begin
            @(negedge clk);
            bus.response_valid = 1'b0;
            bus.error          = 1'b0;
            bus.read_data      = '0;
            if (pend) begin
                if (resp_cnt == 0) begin
                    bus.response_valid = 1'b1;
                    bus.read_data      = pend_data;
                    bus.error          = pend_err;
                    pend = 0;
                end else begin
                    resp_cnt--;
                end
            end
            bus.request_ready = 1'b0;
            if (rst_n && bus.request_valid) begin
                if (wait_cnt < stall_target) begin
                    wait_cnt++;
                end else begin
                    bus.request_ready = 1'b1;
                    wait_cnt = 0;
                    if (bus.write) begin
                        n_writes++;
                        last_wdata = bus.write_data;
                        pend_data  = '0;
                        if (!mapped(bus.address) || read_only(bus.address)) begin
                            pend_err = 1'b1;
                        end else begin
                            pend_err = 1'b0;
                            bus_mem[bus.address] = bus.write_data;
                        end
                    end else begin
                        n_reads++;
                        if (!mapped(bus.address)) begin
                            pend_err  = 1'b1;
                            pend_data = '0;
                        end else begin
                            pend_err  = 1'b0;
                            pend_data = (bus.address == 12'hC00) ? cyc : bus_mem[bus.address];
                        end
                        last_rdata = pend_data;
                    end
                    pend = 1;
                    resp_cnt = rand_mode ? int'($urandom_range(0, 2)) : resp_delay;
                    if (rand_mode) stall_target = $urandom_range(0, 2);
                end
            end
        end
    end

    // One instruction: drive, observe, then compare with the CSR-file model.
    // flush_lat > 0 pulses i_flush that many cycles after acceptance;
    // exp_lat < 0 skips the latency comparison.
    task automatic run_txn(input string tag, input logic [1:0] t_op, input logic [AW-1:0] t_addr,
                           input logic [31:0] t_opnd, input bit t_rs1z, input bit t_rdz,
                           input int flush_lat, input int exp_lat);
        int          r0, w0, lat, got_lat;
        bit          seen, killed, nr, nw, illegal, e_err;
        int          e_reads, e_writes;
        logic [31:0] old, e_wd, e_rd, got_rd;
        logic        got_err;
        r0 = n_reads;
        w0 = n_writes;
        @(negedge clk);
        valid = 1'b1; op = t_op; addr = t_addr; operand = t_opnd; rs1z = t_rs1z; rdz = t_rdz;
        @(negedge clk);
        valid = 1'b0;
        lat = 1; seen = 0; got_lat = 0; got_rd = '0; got_err = 1'b0;
        forever begin
            flush = (lat == flush_lat);
            #1;
            if (done && !seen) begin
                seen = 1; got_lat = lat; got_rd = rdv; got_err = err;
            end
            if (!busy || lat > 300) break;
            @(negedge clk);
            lat++;
        end
        flush = 1'b0;
        check({tag, ".finished"}, 32'(lat <= 300), 32'd1);

        // Reference model: Zicsr semantics on an ideal CSR file
        killed  = (flush_lat > 0);
        nr      = !(t_op == 2'b01 && t_rdz);
        nw      = (t_op == 2'b01) || !t_rs1z;
        illegal = (t_op == 2'b00);
`ifdef RICE_CORE_CSR_READ_ONLY_CHECK_EN
        if (nw && read_only(t_addr)) illegal = 1;
`endif
        e_err = illegal; e_reads = 0; e_writes = 0; old = '0; e_wd = '0;
        if (!illegal) begin
            if (nr) begin
                e_reads = 1;
                if (!mapped(t_addr)) e_err = 1;
                else old = (t_addr == 12'hC00) ? last_rdata : ref_mem[t_addr];
            end
            if (nw && !e_err && !(killed && nr)) begin
                e_writes = 1;
                case (t_op)
                    2'b10:   e_wd = old | t_opnd;
                    2'b11:   e_wd = old & ~t_opnd;
                    default: e_wd = t_opnd;
                endcase
                if (!mapped(t_addr) || read_only(t_addr)) e_err = 1;
                else ref_mem[t_addr] = e_wd;
            end
        end
        e_rd = (nr && !illegal) ? old : '0;

        check({tag, ".done"}, 32'(seen), 32'(!killed));
        if (!killed && seen) begin
            check({tag, ".rd"}, got_rd, e_rd);
            check({tag, ".err"}, 32'(got_err), 32'(e_err));
            if (exp_lat >= 0) check({tag, ".lat"}, got_lat, exp_lat);
        end
        check({tag, ".reads"}, n_reads - r0, e_reads);
        check({tag, ".writes"}, n_writes - w0, e_writes);
        if (e_writes == 1 && n_writes - w0 == 1) check({tag, ".wdata"}, last_wdata, e_wd);
        check({tag, ".mem"}, bus_mem[t_addr], ref_mem[t_addr]);
    endtask

    initial begin : main
        logic [AW-1:0] addr_tab [0:7];
        logic [1:0]    r_op;
        logic [AW-1:0] r_addr;
        logic [31:0]   r_opnd;
        bit            r_rs1z, r_rdz;
        int            r_flush;
        addr_tab = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h343, 12'hC00, 12'hF11, 12'h7C0};
        for (int i = 0; i < 4096; i++) begin
            bus_mem[i] = '0;
            ref_mem[i] = '0;
        end
        bus_mem[12'h340] = 32'h0000_00F0; ref_mem[12'h340] = 32'h0000_00F0;
        bus_mem[12'h300] = 32'h0000_1800; ref_mem[12'h300] = 32'h0000_1800;
        bus_mem[12'hF11] = 32'h0001_2345; ref_mem[12'hF11] = 32'h0001_2345;

        repeat (3) @(negedge clk);
        check("rst.ready", 32'(ready), 32'd1);
        check("rst.done", 32'(done), 32'd0);
        check("rst.rd", rdv, 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.req_valid", 32'(bus.request_valid), 32'd0);
        check("rst.rsp_ready", 32'(bus.response_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases on a zero-wait slave
        run_txn("rmw_set", 2'b10, 12'h340, 32'h0F, 1'b0, 1'b0, 0, 5);
        run_txn("rw_rd0", 2'b01, 12'h305, 32'h8000_0000, 1'b0, 1'b1, 0, 3);
        run_txn("rc_rs0", 2'b11, 12'hC00, 32'h0, 1'b1, 1'b0, 0, 3);
`ifdef RICE_CORE_CSR_READ_ONLY_CHECK_EN
        run_txn("rw_ro", 2'b01, 12'hF11, 32'h55, 1'b0, 1'b0, 0, 1);
`else
        run_txn("rw_ro", 2'b01, 12'hF11, 32'h55, 1'b0, 1'b0, 0, 5);
`endif
        run_txn("rs_unmapped", 2'b10, 12'h7C0, 32'h1, 1'b0, 1'b0, 0, 3);
        run_txn("illegal_op", 2'b00, 12'h300, 32'h3, 1'b0, 1'b0, 0, 1);

        stall_target = 3;
        resp_delay   = 2;
        run_txn("flush_rsp", 2'b10, 12'h341, 32'h3, 1'b0, 1'b0, 5, -1);
        stall_target = 0;
        resp_delay   = 0;
        run_txn("after_flush", 2'b01, 12'h343, 32'hA5A5_0001, 1'b0, 1'b0, 0, 5);

        // Randomized instruction stream with a stalling slave
        rand_mode    = 1;
        stall_target = $urandom_range(0, 2);
        for (int n = 0; n < 60; n++) begin
            r_op    = 2'($urandom_range(0, 3));
            r_addr  = addr_tab[$urandom_range(0, 7)];
            r_rs1z  = ($urandom_range(0, 3) == 0);
            r_rdz   = ($urandom_range(0, 3) == 0);
            r_opnd  = r_rs1z ? 32'h0 : $urandom;
            r_flush = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_txn("rand", r_op, r_addr, r_opnd, r_rs1z, r_rdz, r_flush, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
